// File: rtl/dut_input_frame_buffer.sv
// Write-side frame buffer: captures chip-select/write-enable words into a FIFO and
// releases only complete FRAME_LEN-word frames as a valid/ready stream. Optional FRAME_CHECKSUM_EN.
module dut_input_frame_buffer #(
   parameter int DEPTH     = 16,
   parameter int FRAME_LEN = 8
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     chip_sel,
   input  logic                                     wr_en,
   input  logic [15:0]                              DATA_BUS,
   input  logic                                     clear,
   output logic [15:0]                              out_data,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic                                     out_last,
   output logic                                     overflow,
   output logic [$clog2(DEPTH/FRAME_LEN+1):0]       frames_pending
`ifdef FRAME_CHECKSUM_EN
   ,
   output logic [15:0]                              out_checksum,
   output logic                                     checksum_valid
`endif
);

   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int IW  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int FPW = $clog2(DEPTH/FRAME_LEN+1) + 1;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   logic [15:0]    r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;
   logic [IW-1:0]  r_wr_idx;
   logic [IW-1:0]  r_rd_idx;
   logic [FPW-1:0] r_frames_pending;
   logic           r_overflow;
   state_t         r_state;
   state_t         w_state_next;

   logic w_wr_req;
   logic w_full;
   logic w_wr_acc;
   logic w_rd_acc;
   logic w_frame_done;
   logic w_last_acc;
   logic w_stream;
   logic w_last_beat;

   // Fullness is judged on the count before the edge, so a same-edge read never frees a slot.
   assign w_full       = (r_count == CW'(DEPTH));
   assign w_wr_req     = chip_sel & wr_en & ~clear;
   assign w_wr_acc     = w_wr_req & ~w_full;
   assign w_stream     = (r_state == ST_STREAM);
   assign w_last_beat  = (r_rd_idx == IW'(FRAME_LEN - 1));
   assign w_rd_acc     = w_stream & out_ready;
   assign w_frame_done = w_wr_acc & (r_wr_idx == IW'(FRAME_LEN - 1));
   assign w_last_acc   = w_rd_acc & w_last_beat;

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= DATA_BUS;
      end
   end

   // An empty FIFO presents zero rather than stale memory contents.
   assign out_data       = (r_count != '0) ? r_mem[r_rd_ptr] : 16'h0000;
   assign overflow       = r_overflow;
   assign frames_pending = r_frames_pending;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_wr_idx <= '0;
         r_rd_idx <= '0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_wr_idx <= '0;
         r_rd_idx <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
            r_wr_idx <= (r_wr_idx == IW'(FRAME_LEN - 1)) ? '0 : r_wr_idx + IW'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
            r_rd_idx <= w_last_beat ? '0 : r_rd_idx + IW'(1);
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_frames_pending <= '0;
         r_overflow       <= 1'b0;
      end else if (clear) begin
         r_frames_pending <= '0;
         r_overflow       <= 1'b0;
      end else begin
         if (chip_sel & wr_en & w_full) begin
            r_overflow <= 1'b1;
         end
         case ({w_frame_done, w_last_acc})
            2'b10:   r_frames_pending <= r_frames_pending + FPW'(1);
            2'b01:   r_frames_pending <= r_frames_pending - FPW'(1);
            default: r_frames_pending <= r_frames_pending;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Leaving STREAM on the last beat always costs one IDLE cycle before the next frame.
   always_comb begin
      w_state_next = r_state;
      out_valid    = 1'b0;
      out_last     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_frames_pending != '0) begin
               w_state_next = ST_STREAM;
            end
         end
         ST_STREAM: begin
            out_valid = 1'b1;
            out_last  = w_last_beat;
            if (w_last_acc) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
      if (clear) begin
         w_state_next = ST_IDLE;
      end
   end

`ifdef FRAME_CHECKSUM_EN
   logic [15:0] r_accum;
   logic [15:0] r_checksum;
   logic        r_checksum_valid;

   assign out_checksum   = r_checksum;
   assign checksum_valid = r_checksum_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_accum          <= '0;
         r_checksum       <= '0;
         r_checksum_valid <= 1'b0;
      end else if (clear) begin
         r_accum          <= '0;
         r_checksum       <= '0;
         r_checksum_valid <= 1'b0;
      end else begin
         r_checksum_valid <= 1'b0;
         if (w_last_acc) begin
            r_checksum       <= r_accum + out_data;
            r_checksum_valid <= 1'b1;
            r_accum          <= '0;
         end else if (w_rd_acc) begin
            r_accum <= r_accum + out_data;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dut_input_frame_buffer.sv
// Directed self-checking bench for dut_input_frame_buffer (DEPTH=16, FRAME_LEN=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_dut_input_frame_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        chip_sel;
   logic        wr_en;
   logic [15:0] DATA_BUS;
   logic        clear;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        overflow;
   logic [2:0]  frames_pending;
`ifdef FRAME_CHECKSUM_EN
   logic [15:0] out_checksum;
   logic        checksum_valid;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_q[$];

   dut_input_frame_buffer #(.DEPTH(16), .FRAME_LEN(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .chip_sel       (chip_sel),
      .wr_en          (wr_en),
      .DATA_BUS       (DATA_BUS),
      .clear          (clear),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_last       (out_last),
      .overflow       (overflow),
      .frames_pending (frames_pending)
`ifdef FRAME_CHECKSUM_EN
      ,
      .out_checksum   (out_checksum),
      .checksum_valid (checksum_valid)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] d);
      chip_sel = 1'b1;
      wr_en    = 1'b1;
      DATA_BUS = d;
      tick();
      chip_sel = 1'b0;
      wr_en    = 1'b0;
      $display("write 0x%04h", d);
   endtask

   task automatic wait_valid(input int bound);
      int n = 0;
      while (!out_valid && n < bound) begin
         tick();
         n++;
      end
      check_val("wait_valid", {31'd0, out_valid}, 32'd1);
   endtask

   // Pulls n beats, comparing against exp_q; bp selects the 1,0,0,1 ready pattern.
   task automatic drain(input int n, input bit bp);
      int          beat = 0;
      int          cyc = 0;
      logic [3:0]  pat = 4'b1001;
      logic [15:0] held = '0;
      bit          holding = 0;
      logic [15:0] exp_d;
      while (beat < n && cyc < 200) begin
         out_ready = bp ? pat[3 - (cyc % 4)] : 1'b1;
         if (holding) begin
            check_val("hold_valid", {31'd0, out_valid}, 32'd1);
            check_val("hold_data", {16'd0, out_data}, {16'd0, held});
         end
         if (!bp && (beat % 8) != 0) begin
            check_val("no_gap", {31'd0, out_valid}, 32'd1);
         end
         if (out_valid && out_ready) begin
            exp_d = exp_q.pop_front();
            check_val("beat_data", {16'd0, out_data}, {16'd0, exp_d});
            check_val("beat_last", {31'd0, out_last}, {31'd0, ((beat % 8) == 7)});
            $display("beat %0d data=0x%04h last=%0b", beat, out_data, out_last);
            beat++;
            holding = 0;
         end else if (out_valid) begin
            held    = out_data;
            holding = 1;
         end
         tick();
         cyc++;
      end
      if (beat < n) begin
         check_val("drain_timeout", beat, n);
      end
      out_ready = 1'b1;
   endtask

   initial begin
      int seen;
      reset     = 1'b0;
      chip_sel  = 1'b0;
      wr_en     = 1'b0;
      DATA_BUS  = '0;
      clear     = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      tick();

      // Reset state
      check_val("rst_valid", {31'd0, out_valid}, 32'd0);
      check_val("rst_last", {31'd0, out_last}, 32'd0);
      check_val("rst_data", {16'd0, out_data}, 32'd0);
      check_val("rst_overflow", {31'd0, overflow}, 32'd0);
      check_val("rst_fp", {29'd0, frames_pending}, 32'd0);

      // Pass-through with 3-cycle gaps; wr_en without chip_sel must not write
      for (int i = 1; i <= 8; i++) begin
         wr(16'(i));
         exp_q.push_back(16'(i));
         if (i < 8) begin
            wr_en    = 1'b1;
            DATA_BUS = 16'hDEAD;
            tick();
            wr_en = 1'b0;
            tick();
            tick();
         end
      end
      check_val("pt_fp_after_write", {29'd0, frames_pending}, 32'd1);
      check_val("pt_valid_edgeN", {31'd0, out_valid}, 32'd0);
      tick();
      check_val("pt_valid_edgeN1", {31'd0, out_valid}, 32'd1);
      drain(8, 1'b0);
      check_val("pt_fp_done", {29'd0, frames_pending}, 32'd0);
      check_val("pt_valid_done", {31'd0, out_valid}, 32'd0);

      // Partial frame is held back
      for (int i = 0; i < 7; i++) begin
         wr(16'h0010 + 16'(i));
         exp_q.push_back(16'h0010 + 16'(i));
      end
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         if (out_valid) seen++;
         tick();
      end
      check_val("partial_no_valid", seen, 0);
      wr(16'h0017);
      exp_q.push_back(16'h0017);
      wait_valid(10);
      drain(8, 1'b0);

      // Backpressure
      for (int i = 0; i < 8; i++) begin
         wr(16'hA000 + 16'(i));
         exp_q.push_back(16'hA000 + 16'(i));
      end
      wait_valid(10);
      drain(8, 1'b1);
      check_val("bp_queue_empty", exp_q.size(), 0);

      // Overflow: 17 writes into a 16-deep FIFO with the consumer stalled
      out_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         wr(16'h0100 + 16'(i));
         if (i < 16) exp_q.push_back(16'h0100 + 16'(i));
         if (i == 15) check_val("ovf_before", {31'd0, overflow}, 32'd0);
      end
      check_val("ovf_set", {31'd0, overflow}, 32'd1);
      check_val("ovf_fp", {29'd0, frames_pending}, 32'd2);
      drain(16, 1'b0);
      tick();
      tick();
      check_val("ovf_fp_done", {29'd0, frames_pending}, 32'd0);
      check_val("ovf_no_extra", {31'd0, out_valid}, 32'd0);
      check_val("ovf_sticky", {31'd0, overflow}, 32'd1);

      // Frame 2 completes on the same edge frame 1's last beat is accepted
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) wr(16'hB000 + 16'(i));
      for (int i = 0; i < 7; i++) wr(16'hB100 + 16'(i));
      wait_valid(10);
      for (int i = 0; i < 7; i++) begin
         out_ready = 1'b1;
         check_val("sim_data", {16'd0, out_data}, {16'd0, 16'hB000 + 16'(i)});
         check_val("sim_last_lo", {31'd0, out_last}, 32'd0);
         tick();
      end
      check_val("sim_data7", {16'd0, out_data}, 32'h0000B007);
      check_val("sim_last7", {31'd0, out_last}, 32'd1);
      check_val("sim_fp_before", {29'd0, frames_pending}, 32'd1);
      wr(16'hB107);
      check_val("sim_fp_same", {29'd0, frames_pending}, 32'd1);
      check_val("sim_idle_gap", {31'd0, out_valid}, 32'd0);
      tick();
      check_val("sim_valid_f2", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 8; i++) exp_q.push_back(16'hB100 + 16'(i));
      drain(8, 1'b0);

      // Clear mid-stream (overflow still set from earlier); a same-edge write is discarded
      for (int i = 0; i < 12; i++) wr(16'hC000 + 16'(i));
      clear    = 1'b1;
      chip_sel = 1'b1;
      wr_en    = 1'b1;
      DATA_BUS = 16'hD0DE;
      tick();
      clear    = 1'b0;
      chip_sel = 1'b0;
      wr_en    = 1'b0;
      check_val("clr_valid", {31'd0, out_valid}, 32'd0);
      check_val("clr_fp", {29'd0, frames_pending}, 32'd0);
      check_val("clr_overflow", {31'd0, overflow}, 32'd0);
      check_val("clr_data", {16'd0, out_data}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         wr(16'hD000 + 16'(i));
         exp_q.push_back(16'hD000 + 16'(i));
      end
      wait_valid(10);
      drain(8, 1'b0);

      // Asynchronous reset with two frames pending and overflow set
      out_ready = 1'b0;
      for (int i = 0; i < 17; i++) wr(16'hE000 + 16'(i));
      check_val("rs_pre_overflow", {31'd0, overflow}, 32'd1);
      reset = 1'b0;
      #2;
      check_val("rs_valid", {31'd0, out_valid}, 32'd0);
      check_val("rs_fp", {29'd0, frames_pending}, 32'd0);
      check_val("rs_overflow", {31'd0, overflow}, 32'd0);
      tick();
      reset     = 1'b1;
      out_ready = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         wr(16'hE100 + 16'(i));
         exp_q.push_back(16'hE100 + 16'(i));
      end
      wait_valid(10);
      drain(8, 1'b0);

`ifdef FRAME_CHECKSUM_EN
      begin
         int          pulses = 0;
         logic [15:0] cs = '0;
         wr(16'hFFFF);
         wr(16'h0002);
         for (int i = 0; i < 6; i++) wr(16'h0000);
         for (int i = 0; i < 16; i++) begin
            if (checksum_valid) begin
               pulses++;
               cs = out_checksum;
            end
            tick();
         end
         check_val("cs_pulses", pulses, 1);
         check_val("cs_value", {16'd0, cs}, 32'h00000001);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
